// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state
// encodings, Booth recoding operations and the recoding helper.
package booth_pkg;

  // state | meaning
  // IDLE  | waiting for a start request
  // RUN   | one Booth iteration per cycle
  // DONE  | result_rdy high, result and exception valid
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_m1}
  function automatic booth_op_t booth_op(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/adder_rca.sv
// N-bit ripple-carry adder built from a chain of full_adder cells.
module adder_rca #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell shared with the ALU datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and carry of one bit position
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier. One iteration per cycle over
// WIDTH cycles; returns the low WIDTH bits of the product and flags when the
// full product does not fit in WIDTH signed bits.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             exception
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  booth_op_t        op;
  logic [WIDTH:0]   addend;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             cout_unused;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last;
  logic             load;

  // Booth recode selects +M, ~M (with carry-in for subtract) or zero
  always_comb begin
    op     = booth_op(q[0], q_m1);
    addend = '0;
    cin    = 1'b0;
    case (op)
      OP_ADD: addend = m;
      OP_SUB: begin
        addend = ~m;
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
  end

  // Accumulator is WIDTH+1 bits so the carry out is never needed
  adder_rca #(.N(WIDTH + 1)) u_adder (
    .a    (acc),
    .b    (addend),
    .cin  (cin),
    .sum  (sum),
    .cout (cout_unused)
  );

  // Arithmetic right shift of {sum, Q, q_m1}; q_m1 takes the old Q[0]
  always_comb begin
    acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt   = {sum[0], q[WIDTH-1:1]};
    last    = (cnt == CW'(WIDTH - 1));
    load    = start && ((state == IDLE) || (state == DONE));
  end

  // FSM, iteration counter, shift register and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      m          <= '0;
      acc        <= '0;
      q          <= '0;
      q_m1       <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      result_rdy <= 1'b0;
      result     <= '0;
      exception  <= 1'b0;
    end else begin
      result_rdy <= 1'b0;
      if (load) begin
        m     <= {operand_a[WIDTH-1], operand_a};
        acc   <= '0;
        q     <= operand_b;
        q_m1  <= 1'b0;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            acc  <= acc_nxt;
            q    <= q_nxt;
            q_m1 <= q[0];
            cnt  <= cnt + 1'b1;
            if (last) begin
              state      <= DONE;
              busy       <= 1'b0;
              result_rdy <= 1'b1;
              result     <= q_nxt;
              exception  <= (acc_nxt[WIDTH-1:0] != {WIDTH{q_nxt[WIDTH-1]}});
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq (WIDTH = 32).
module tb_booth_mult_seq;

  localparam int WIDTH = 32;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             result_rdy;
  logic [WIDTH-1:0] result;
  logic             exception;

  int n_checks = 0;
  int n_errors = 0;

  booth_mult_seq #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .result_rdy (result_rdy),
    .result     (result),
    .exception  (exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive start with the operands (called #1 after an edge), then scramble
  // the operand inputs once the start edge has passed.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start     = 1'b1;
    operand_a = a;
    operand_b = b;
    @(posedge clock); #1;
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  // Called #1 after the start edge. Waits for result_rdy and checks the
  // latency (cycle 1 = the cycle after the start edge), busy length and
  // the returned values. ignore_at >= 0 pulses a stray start mid-run.
  task automatic wait_result(input string tag, input logic [WIDTH-1:0] exp_r,
                             input logic exp_e, input int ignore_at);
    int edges    = 0;
    int busy_cnt = 0;
    bit got      = 0;
    while (edges < 60 && !got) begin
      if (result_rdy) got = 1;
      else begin
        if (busy) busy_cnt++;
        if (edges == ignore_at) begin
          start     = 1'b1;
          operand_a = 32'h7FFF_FFFF;
          operand_b = 32'h0000_1234;
        end else begin
          start = 1'b0;
        end
        @(posedge clock); #1;
        edges++;
      end
    end
    start = 1'b0;
    check({tag, " rdy_seen"}, 64'(got), 64'd1);
    check({tag, " rdy_cycle"}, 64'(edges + 1), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, " busy_at_rdy"}, 64'(busy), 64'd0);
    check({tag, " result"}, 64'(result), 64'(exp_r));
    check({tag, " exception"}, 64'(exception), 64'(exp_e));
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_r, input logic exp_e, input int ignore_at);
    launch(a, b);
    wait_result(tag, exp_r, exp_e, ignore_at);
  endtask

  initial begin
    int rdy_hits;
    reset_n   = 1'b0;
    start     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset rdy", 64'(result_rdy), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset exception", 64'(exception), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_op("3x5", 32'd3, 32'd5, 32'h0000_000F, 1'b0, -1);
    @(posedge clock); #1;
    check("3x5 rdy_one_cycle", 64'(result_rdy), 64'd0);
    check("3x5 result_hold", 64'(result), 64'h0000_000F);
    check("3x5 idle_busy", 64'(busy), 64'd0);

    run_op("m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, -1);
    run_op("maxsq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, -1);
    run_op("minxm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, -1);
    run_op("minx1", 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, -1);
    run_op("hi_ovf", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, -1);
    run_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1);
    run_op("ignore", 32'h0000_007B, 32'hFFFF_FFFE, 32'hFFFF_FF0A, 1'b0, 9);

    // start during DONE is accepted immediately
    run_op("b2b_first", 32'h0000_1000, 32'h0000_0030, 32'h0003_0000, 1'b0, -1);
    run_op("b2b_second", 32'hFFFF_FFFD, 32'h0000_0011, 32'hFFFF_FFCD, 1'b0, -1);

    // reset mid-run aborts immediately and produces no result_rdy
    launch(32'h0001_2345, 32'h0000_0010);
    repeat (12) begin
      @(posedge clock); #1;
    end
    check("abort busy_before", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort rdy", 64'(result_rdy), 64'd0);
    check("abort result", 64'(result), 64'd0);
    check("abort exception", 64'(exception), 64'd0);
    rdy_hits = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (result_rdy) rdy_hits++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (25) begin
      @(posedge clock); #1;
      if (result_rdy) rdy_hits++;
    end
    check("abort no_rdy", 64'(rdy_hits), 64'd0);
    check("abort idle", 64'(busy), 64'd0);
    run_op("after_rst", 32'd9, 32'hFFFF_FFFB, 32'hFFFF_FFD3, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
